// File: rtl/axi_rd_responder.sv
// AXI4 read-channel responder: serves one INCR burst at a time from an internal
// word-addressed memory, with a fixed initial latency and full rready backpressure.
module axi_rd_responder #(
  parameter int MEM_AW  = 12,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic              ld_en,
  input  logic [MEM_AW-1:0] ld_addr,
  input  logic [31:0]       ld_data
);

  // AR accepted on arvalid & arready; a beat moves on rvalid & rready. rdata,
  // rresp and rlast hold while rvalid=1 and rready=0.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t state, state_n;

  logic [31:0] mem [2**MEM_AW];

  logic [MEM_AW-1:0] base_word, base_word_n;
  logic [7:0]        len, len_n;
  logic [7:0]        beat_cnt, beat_cnt_n;
  logic [3:0]        lat_cnt, lat_cnt_n;
  logic              dec_err, dec_err_n;
  logic              size_err, size_err_n;

  logic              arready_n, rvalid_n, rlast_n;
  logic [31:0]       rdata_n;
  logic [1:0]        rresp_n;

  logic [MEM_AW-1:0] req_word;
  logic              req_dec, req_size;
  logic              unused_lsb;

  logic              do_load;
  logic [MEM_AW-1:0] beat_base, rd_word;
  logic [7:0]        beat_idx, beat_len;
  logic              beat_dec, beat_size;

  assign req_word   = araddr[MEM_AW+1:2];
  assign req_dec    = |araddr[31:MEM_AW+2];
  assign req_size   = (arsize != 3'd2);
  assign unused_lsb = ^araddr[1:0];

  always_comb begin
    state_n     = state;
    base_word_n = base_word;
    len_n       = len;
    beat_cnt_n  = beat_cnt;
    lat_cnt_n   = lat_cnt;
    dec_err_n   = dec_err;
    size_err_n  = size_err;
    arready_n   = arready;
    rvalid_n    = rvalid;
    rlast_n     = rlast;
    rdata_n     = rdata;
    rresp_n     = rresp;
    do_load     = 1'b0;
    beat_base   = base_word;
    beat_idx    = beat_cnt;
    beat_len    = len;
    beat_dec    = dec_err;
    beat_size   = size_err;

    case (state)
      IDLE: begin
        if (arvalid && arready) begin
          base_word_n = req_word;
          len_n       = arlen;
          dec_err_n   = req_dec;
          size_err_n  = req_size;
          arready_n   = 1'b0;
          beat_cnt_n  = 8'd0;
          if (LATENCY == 0) begin
            // First beat comes straight from the request, not the capture regs.
            do_load   = 1'b1;
            beat_base = req_word;
            beat_idx  = 8'd0;
            beat_len  = arlen;
            beat_dec  = req_dec;
            beat_size = req_size;
            state_n   = BURST;
          end else begin
            lat_cnt_n = 4'(LATENCY);
            state_n   = WAIT;
          end
        end
      end
      WAIT: begin
        if (lat_cnt <= 4'd1) begin
          do_load   = 1'b1;
          beat_idx  = 8'd0;
          lat_cnt_n = 4'd0;
          state_n   = BURST;
        end else begin
          lat_cnt_n = lat_cnt - 4'd1;
        end
      end
      BURST: begin
        if (rready) begin
          if (rlast) begin
            rvalid_n  = 1'b0;
            rlast_n   = 1'b0;
            arready_n = 1'b1;
            state_n   = IDLE;
          end else begin
            do_load    = 1'b1;
            beat_idx   = beat_cnt + 8'd1;
            beat_cnt_n = beat_cnt + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Word address wraps at the top of the array.
    rd_word = beat_base + MEM_AW'(beat_idx);
    if (do_load) begin
      rvalid_n = 1'b1;
      rlast_n  = (beat_idx == beat_len);
      rdata_n  = beat_dec ? 32'd0 : mem[rd_word];
      rresp_n  = beat_dec ? 2'b11 : (beat_size ? 2'b10 : 2'b00);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      base_word <= '0;
      len       <= 8'd0;
      beat_cnt  <= 8'd0;
      lat_cnt   <= 4'd0;
      dec_err   <= 1'b0;
      size_err  <= 1'b0;
      arready   <= 1'b1;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rdata     <= 32'd0;
      rresp     <= 2'b00;
    end else begin
      state     <= state_n;
      base_word <= base_word_n;
      len       <= len_n;
      beat_cnt  <= beat_cnt_n;
      lat_cnt   <= lat_cnt_n;
      dec_err   <= dec_err_n;
      size_err  <= size_err_n;
      arready   <= arready_n;
      rvalid    <= rvalid_n;
      rlast     <= rlast_n;
      rdata     <= rdata_n;
      rresp     <= rresp_n;
    end
  end

  // Memory is not reset; a same-edge preload to the word being read returns the old value.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed bench for axi_rd_responder: one instance with LATENCY=2, one with LATENCY=0,
// a table of bursts plus hand-written reset and read-before-write sequences.
module tb_axi_rd_responder;

  logic        clk;
  logic        resetn;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid_drv, rready_drv, sel;
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [31:0] ld_data;

  logic        arvalid_a, rready_a, arready_a, rlast_a, rvalid_a;
  logic [31:0] rdata_a;
  logic [1:0]  rresp_a;
  logic        arvalid_b, rready_b, arready_b, rlast_b, rvalid_b;
  logic [31:0] rdata_b;
  logic [1:0]  rresp_b;

  logic        obs_arready, obs_rvalid, obs_rlast;
  logic [31:0] obs_rdata;
  logic [1:0]  obs_rresp;

  logic [31:0] ref_mem [4096];
  int checks = 0;
  int errors = 0;

  assign arvalid_a = !sel && arvalid_drv;
  assign rready_a  = !sel && rready_drv;
  assign arvalid_b = sel && arvalid_drv;
  assign rready_b  = sel && rready_drv;

  assign obs_arready = sel ? arready_b : arready_a;
  assign obs_rvalid  = sel ? rvalid_b  : rvalid_a;
  assign obs_rlast   = sel ? rlast_b   : rlast_a;
  assign obs_rdata   = sel ? rdata_b   : rdata_a;
  assign obs_rresp   = sel ? rresp_b   : rresp_a;

  axi_rd_responder #(.MEM_AW(12), .LATENCY(2)) dut (
    .clk(clk), .resetn(resetn), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid_a), .arready(arready_a), .rdata(rdata_a), .rresp(rresp_a),
    .rlast(rlast_a), .rvalid(rvalid_a), .rready(rready_a),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  axi_rd_responder #(.MEM_AW(12), .LATENCY(0)) dut0 (
    .clk(clk), .resetn(resetn), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid_b), .arready(arready_b), .rdata(rdata_b), .rresp(rresp_b),
    .rlast(rlast_b), .rvalid(rvalid_b), .rready(rready_b),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    int          mode;   // 0: rready always 1, 1: rready pattern 1,0,0
    logic        use_l0; // 1: target the LATENCY=0 instance
    logic [1:0]  resp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [31:0] addr, input int i);
    logic [11:0] w;
    if (addr[31:14] != 18'd0) return 32'd0;
    w = addr[13:2] + 12'(i);
    return ref_mem[w];
  endfunction

  // driver: one complete burst on the selected instance, checked beat by beat
  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input int mode, input logic [1:0] eresp);
    int lat, beat, cyc, exp_lat;
    logic hs;
    exp_lat = sel ? 0 : 2;
    @(negedge clk);
    check("arready_idle", {31'd0, obs_arready}, 32'd1);
    araddr = addr; arlen = len; arsize = size; arvalid_drv = 1'b1;
    @(posedge clk); #1;
    arvalid_drv = 1'b0;
    check("arready_drop", {31'd0, obs_arready}, 32'd0);
    lat = 0;
    while (!obs_rvalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("first_latency", 32'(lat), 32'(exp_lat));
    beat = 0;
    cyc = 0;
    while (beat <= int'(len) && cyc < 2000) begin
      @(negedge clk);
      rready_drv = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (obs_rvalid) begin
        check("rdata", obs_rdata, exp_data(addr, beat));
        check("rresp", {30'd0, obs_rresp}, {30'd0, eresp});
        check("rlast", {31'd0, obs_rlast}, {31'd0, beat == int'(len)});
      end else begin
        check("rvalid_bubble", {31'd0, obs_rvalid}, 32'd1);
      end
      hs = obs_rvalid && rready_drv;
      @(posedge clk);
      if (hs) beat++;
      cyc++;
    end
    #1;
    rready_drv = 1'b0;
    check("beat_count", 32'(beat), 32'(int'(len) + 1));
    check("rvalid_after", {31'd0, obs_rvalid}, 32'd0);
    check("rlast_after", {31'd0, obs_rlast}, 32'd0);
    check("arready_after", {31'd0, obs_arready}, 32'd1);
  endtask

  initial begin
    int beat, cnt;
    logic hs;
    vecs[0]  = '{32'h0000_0000, 8'd7,   3'd2, 0, 1'b0, 2'b00};
    vecs[1]  = '{32'h0000_0000, 8'd7,   3'd2, 1, 1'b0, 2'b00};
    vecs[2]  = '{32'h0000_3FF8, 8'd3,   3'd2, 0, 1'b0, 2'b00};
    vecs[3]  = '{32'h0001_0000, 8'd1,   3'd2, 0, 1'b0, 2'b11};
    vecs[4]  = '{32'h0000_0020, 8'd0,   3'd3, 0, 1'b0, 2'b10};
    vecs[5]  = '{32'h0001_0000, 8'd0,   3'd5, 1, 1'b0, 2'b11};
    vecs[6]  = '{32'h0000_0013, 8'd2,   3'd2, 1, 1'b0, 2'b00};
    vecs[7]  = '{32'h0000_0400, 8'd255, 3'd2, 0, 1'b0, 2'b00};
    vecs[8]  = '{32'h0000_0040, 8'd0,   3'd2, 0, 1'b1, 2'b00};
    vecs[9]  = '{32'h0000_0044, 8'd0,   3'd2, 0, 1'b1, 2'b00};
    vecs[10] = '{32'h0000_3FFC, 8'd1,   3'd2, 1, 1'b1, 2'b00};

    resetn = 1'b0; sel = 1'b0; arvalid_drv = 1'b0; rready_drv = 1'b0;
    araddr = '0; arlen = '0; arsize = 3'd2; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_arready", {31'd0, arready_a}, 32'd1);
    check("reset_rvalid", {31'd0, rvalid_a}, 32'd0);
    check("reset_rlast", {31'd0, rlast_a}, 32'd0);
    check("reset_rdata", rdata_a, 32'd0);
    check("reset_rresp", {30'd0, rresp_a}, 32'd0);
    check("reset_arready_l0", {31'd0, arready_b}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;

    for (int w = 0; w < 4096; w++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = 12'(w); ld_data = 32'h1000_0000 + 32'(w);
      ref_mem[w] = 32'h1000_0000 + 32'(w);
    end
    @(negedge clk);
    ld_en = 1'b0;

    for (int v = 0; v < 11; v++) begin
      sel = vecs[v].use_l0;
      run_burst(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].mode, vecs[v].resp);
    end

    // read-before-write: preload hits the word loaded on the handshake edge
    sel = 1'b1;
    @(negedge clk);
    araddr = 32'h0000_0080; arlen = 8'd0; arsize = 3'd2; arvalid_drv = 1'b1;
    ld_en = 1'b1; ld_addr = 12'd32; ld_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    arvalid_drv = 1'b0; ld_en = 1'b0;
    ref_mem[32] = 32'hDEAD_BEEF;
    check("rbw_rvalid", {31'd0, obs_rvalid}, 32'd1);
    check("rbw_old_data", obs_rdata, 32'h1000_0020);
    check("rbw_rlast", {31'd0, obs_rlast}, 32'd1);
    @(negedge clk);
    rready_drv = 1'b1;
    @(posedge clk); #1;
    rready_drv = 1'b0;
    check("rbw_done", {31'd0, obs_rvalid}, 32'd0);
    run_burst(32'h0000_0080, 8'd0, 3'd2, 0, 2'b00);

    // reset asserted while beat 3 of an 8-beat burst is presented
    sel = 1'b0;
    @(negedge clk);
    araddr = 32'h0; arlen = 8'd7; arsize = 3'd2; arvalid_drv = 1'b1;
    @(posedge clk); #1;
    arvalid_drv = 1'b0;
    beat = 0;
    cnt = 0;
    while (cnt < 50) begin
      @(negedge clk);
      rready_drv = 1'b1;
      if (obs_rvalid && beat == 3) break;
      hs = obs_rvalid && rready_drv;
      @(posedge clk);
      if (hs) beat++;
      cnt++;
    end
    check("rst_reached_beat3", 32'(beat), 32'd3);
    check("rst_beat3_data", obs_rdata, 32'h1000_0003);
    resetn = 1'b0;
    #1;
    rready_drv = 1'b0;
    check("rst_async_rvalid", {31'd0, obs_rvalid}, 32'd0);
    check("rst_async_arready", {31'd0, obs_arready}, 32'd1);
    check("rst_async_rlast", {31'd0, obs_rlast}, 32'd0);
    check("rst_async_rdata", obs_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_no_beats", {31'd0, obs_rvalid}, 32'd0);
    end
    run_burst(32'h0000_0000, 8'd7, 3'd2, 0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
